instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 62 ++++++
 rtl/instr_encoder_if.sv | 29 ++
 rtl/instr_encoder_pack.sv | 69 ++++++
 rtl/instr_encoder.sv | 92 +++++++++
 tb/tb_instr_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: opcodes, ALU codes, class codes,
// NOP word, FSM state type and the ALU-code -> funct3/bit30 helper.
package instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_LUI  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR
  } instr_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} enc_state_e;

  typedef struct packed {
    logic [2:0] f3;
    logic       b30;
    logic       bad;
  } alu_enc_t;

  function automatic alu_enc_t alu_encode(input logic [3:0] alu);
    alu_enc_t r;
    r = '0;
    case (alu)
      ALU_ADD:  r.f3 = 3'b000;
      ALU_SUB:  r.b30 = 1'b1;
      ALU_SLL:  r.f3 = 3'b001;
      ALU_SLT:  r.f3 = 3'b010;
      ALU_SLTU: r.f3 = 3'b011;
      ALU_XOR:  r.f3 = 3'b100;
      ALU_SRL:  r.f3 = 3'b101;
      ALU_SRA:  begin r.f3 = 3'b101; r.b30 = 1'b1; end
      ALU_OR:   r.f3 = 3'b110;
      ALU_AND:  r.f3 = 3'b111;
      // lui is a decoder-side code with no R/I encoding
      ALU_LUI:  r.bad = 1'b1;
      default:  r.bad = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and imem write-port output of the instruction encoder.
interface instr_encoder_if #(parameter int unsigned ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [3:0]        in_alu;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_word;

  modport slave (
    input  in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_last,
    input  out_ready,
    output in_ready, out_valid, out_addr, out_word
  );

  modport master (
    output in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_last,
    output out_ready,
    input  in_ready, out_valid, out_addr, out_word
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction class and fields -> RV32I word, with illegal
// bundles replaced by a NOP and flagged.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  class_i,
  input  logic [3:0]  alu_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  alu_enc_t    ae;
  logic        is_shift;
  logic        bad;
  logic [31:0] raw;

  always_comb begin
    ae       = alu_encode(alu_i);
    is_shift = (alu_i == ALU_SLL) || (alu_i == ALU_SRL) || (alu_i == ALU_SRA);
    raw      = '0;
    bad      = 1'b0;
    case (class_i)
      CLS_R: begin
        raw = {1'b0, ae.b30, 5'b0, rs2_i, rs1_i, ae.f3, rd_i, OP_R};
        bad = ae.bad;
      end
      CLS_I: begin
        if (is_shift) begin
          raw = {1'b0, alu_i == ALU_SRA, 5'b0, imm_i[4:0], rs1_i, ae.f3, rd_i, OP_I};
          bad = |imm_i[11:5];
        end else begin
          raw = {imm_i[11:0], rs1_i, ae.f3, rd_i, OP_I};
          bad = ae.bad || (alu_i == ALU_SUB);
        end
      end
      CLS_LOAD: begin
        raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        bad = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      end
      CLS_STORE: begin
        raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        bad = funct3_i > 3'b010;
      end
      CLS_BRANCH: begin
        raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OP_BRANCH};
        bad = (funct3_i == 3'b010) || (funct3_i == 3'b011) || imm_i[0];
      end
      CLS_LUI:   raw = {imm_i[31:12], rd_i, OP_LUI};
      CLS_AUIPC: raw = {imm_i[31:12], rd_i, OP_AUIPC};
      CLS_JAL: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        bad = imm_i[0];
      end
      CLS_JALR: begin
        raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_JALR};
        bad = funct3_i != 3'b000;
      end
      default: bad = 1'b1;
    endcase
    illegal_o = bad;
    word_o    = bad ? NOP_WORD : raw;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: session FSM, one-deep output register and the
// address/count bookkeeping for the imem write port.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  enc_state_e        state_q;
  logic              out_valid_q;
  logic              last_q;
  logic              err_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        in_ready;
  logic        accept;
  logic        out_hs;

  instr_pack u_pack (
    .class_i   (bus.in_class),
    .alu_i     (bus.in_alu),
    .rd_i      (bus.in_rd),
    .rs1_i     (bus.in_rs1),
    .rs2_i     (bus.in_rs2),
    .funct3_i  (bus.in_funct3),
    .imm_i     (bus.in_imm),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
    end else if (start) begin
      // Restart drops any pending word; a bundle accepted this cycle opens the new session.
      state_q     <= ST_RUN;
      addr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= accept;
      last_q      <= accept && bus.in_last;
      err_q       <= accept && pack_illegal;
      if (accept) word_q <= pack_word;
    end else begin
      if (out_hs) begin
        addr_q <= addr_q + 1'b1;
        if (!count_q[ADDR_W]) count_q <= count_q + 1'b1;
        if (last_q) state_q <= ST_DONE;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        word_q      <= pack_word;
        last_q      <= bus.in_last;
        if (pack_illegal) err_q <= 1'b1;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_addr  = addr_q;
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
  assign count         = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, stall/reset/wrap sequences and a
// randomized stream checked against an arithmetic encoding model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  logic start8, start2;
  logic busy8, done8, err8;
  logic [8:0] count8;
  logic busy2, done2, err2;
  logic [2:0] count2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) b8 ();
  instr_encoder_if #(.ADDR_W(2)) b2 ();

  instr_encoder #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .bus(b8.slave),
    .busy(busy8), .done(done8), .err(err8), .count(count8)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(b2.slave),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  typedef struct {
    logic [3:0]  c;
    logic [3:0]  a;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Encoding built from field positions with plain arithmetic; bit 32 = illegal.
  function automatic logic [32:0] ref_enc(input logic [3:0] c, input logic [3:0] a,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [31:0] imm);
    int unsigned w, af, d, s1, s2, fn, im;
    bit bad, abad, shift;
    d = rd; s1 = rs1; s2 = rs2; fn = f3; im = imm;
    abad = 0; af = 0; bad = 0; w = 0;
    case (a)
      0, 1: af = 0;
      3: af = 7;
      4: af = 4;
      5: af = 6;
      6: af = 1;
      7, 8: af = 5;
      9: af = 2;
      10: af = 3;
      default: abad = 1;
    endcase
    shift = (a >= 6) && (a <= 8);
    case (c)
      0: begin
        w = 'h33 + d*128 + af*4096 + s1*32768 + s2*(1<<20) + ((a == 1 || a == 8) ? (1<<30) : 0);
        bad = abad;
      end
      1: begin
        if (shift) begin
          w = 'h13 + d*128 + af*4096 + s1*32768 + (im%32)*(1<<20) + ((a == 8) ? (1<<30) : 0);
          bad = ((im/32)%128) != 0;
        end else begin
          w = 'h13 + d*128 + af*4096 + s1*32768 + (im%4096)*(1<<20);
          bad = abad || (a == 1);
        end
      end
      2: begin
        w = 'h03 + d*128 + fn*4096 + s1*32768 + (im%4096)*(1<<20);
        bad = (fn == 3) || (fn == 6) || (fn == 7);
      end
      3: begin
        w = 'h23 + (im%32)*128 + fn*4096 + s1*32768 + s2*(1<<20) + ((im/32)%128)*(1<<25);
        bad = fn > 2;
      end
      4: begin
        w = 'h63 + ((im/2048)%2)*128 + ((im/2)%16)*256 + fn*4096 + s1*32768 + s2*(1<<20)
            + ((im/32)%64)*(1<<25) + ((im/4096)%2)*32'h8000_0000;
        bad = (fn == 2) || (fn == 3) || (im%2 == 1);
      end
      5: w = 'h37 + d*128 + (im/4096)*4096;
      6: w = 'h17 + d*128 + (im/4096)*4096;
      7: begin
        w = 'h6F + d*128 + ((im/4096)%256)*4096 + ((im/2048)%2)*(1<<20)
            + ((im/2)%1024)*(1<<21) + ((im/(1<<20))%2)*32'h8000_0000;
        bad = im%2 == 1;
      end
      8: begin
        w = 'h67 + d*128 + fn*4096 + s1*32768 + (im%4096)*(1<<20);
        bad = fn != 0;
      end
      default: bad = 1;
    endcase
    return {bad, bad ? 32'h13 : w};
  endfunction

  task automatic drive8(input logic [3:0] c, input logic [3:0] a, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, input logic last);
    b8.in_class = c; b8.in_alu = a; b8.in_rd = rd; b8.in_rs1 = rs1; b8.in_rs2 = rs2;
    b8.in_funct3 = f3; b8.in_imm = imm; b8.in_last = last; b8.in_valid = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    chk($sformatf("vec%0d_busy", idx), busy8, 1);
    drive8(v.c, v.a, v.rd, v.rs1, v.rs2, v.f3, v.imm, 1'b1);
    b8.out_ready = 1'b0;
    #1 chk($sformatf("vec%0d_in_ready", idx), b8.in_ready, 1);
    @(negedge clk); b8.in_valid = 1'b0;
    chk($sformatf("vec%0d_valid", idx), b8.out_valid, 1);
    chk($sformatf("vec%0d_word", idx), b8.out_word, v.word);
    chk($sformatf("vec%0d_addr", idx), b8.out_addr, 0);
    chk($sformatf("vec%0d_err", idx), err8, v.err);
    b8.out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_done", idx), done8, 1);
    chk($sformatf("vec%0d_count", idx), count8, 1);
    chk($sformatf("vec%0d_valid_after", idx), b8.out_valid, 0);
    b8.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_addr, exp_cnt;
    bit exp_err;
    logic [32:0] r;

    reset = 1'b1; start8 = 1'b0; start2 = 1'b0;
    b8.in_valid = 0; b8.in_class = 0; b8.in_alu = 0; b8.in_rd = 0; b8.in_rs1 = 0;
    b8.in_rs2 = 0; b8.in_funct3 = 0; b8.in_imm = 0; b8.in_last = 0; b8.out_ready = 0;
    b2.in_valid = 0; b2.in_class = 0; b2.in_alu = 0; b2.in_rd = 0; b2.in_rs1 = 0;
    b2.in_rs2 = 0; b2.in_funct3 = 0; b2.in_imm = 0; b2.in_last = 0; b2.out_ready = 0;

    //            c  a  rd rs1 rs2 f3 imm             word           err
    vecs.push_back('{4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5,         32'h0050_0093, 1'b0});
    vecs.push_back('{4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0,         32'h0020_81B3, 1'b0});
    vecs.push_back('{4'd0, 4'd1, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0,         32'h4020_81B3, 1'b0});
    vecs.push_back('{4'd3, 4'd0, 5'd7, 5'd1, 5'd2, 3'd2, 32'd8,         32'h0020_A423, 1'b0});
    vecs.push_back('{4'd5, 4'd0, 5'd5, 5'd3, 5'd4, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0});
    vecs.push_back('{4'd7, 4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd16,        32'h0100_00EF, 1'b0});
    vecs.push_back('{4'd0, 4'd2, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0,         32'h0000_0013, 1'b1});
    vecs.push_back('{4'd1, 4'd8, 5'd1, 5'd2, 5'd0, 3'd0, 32'd3,         32'h4031_5093, 1'b0});
    vecs.push_back('{4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8,         32'h0020_8463, 1'b0});
    vecs.push_back('{4'd4, 4'd0, 5'd9, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0});
    vecs.push_back('{4'd2, 4'd0, 5'd5, 5'd1, 5'd9, 3'd2, 32'd4,         32'h0040_A283, 1'b0});
    vecs.push_back('{4'd8, 4'd0, 5'd0, 5'd1, 5'd0, 3'd0, 32'd0,         32'h0000_8067, 1'b0});
    vecs.push_back('{4'd6, 4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_1000, 32'h0000_1097, 1'b0});
    vecs.push_back('{4'd7, 4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFF8, 32'hFF9F_F06F, 1'b0});
    vecs.push_back('{4'd1, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5,         32'h0000_0013, 1'b1});
    vecs.push_back('{4'd7, 4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd17,        32'h0000_0013, 1'b1});
    vecs.push_back('{4'd9, 4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0,         32'h0000_0013, 1'b1});
    vecs.push_back('{4'd1, 4'd6, 5'd1, 5'd2, 5'd0, 3'd0, 32'h20,        32'h0000_0013, 1'b1});
    vecs.push_back('{4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,         32'h0000_0013, 1'b1});
    vecs.push_back('{4'd2, 4'd0, 5'd5, 5'd1, 5'd0, 3'd3, 32'd4,         32'h0000_0013, 1'b1});
    vecs.push_back('{4'd3, 4'd0, 5'd0, 5'd1, 5'd2, 3'd3, 32'd8,         32'h0000_0013, 1'b1});
    vecs.push_back('{4'd8, 4'd0, 5'd1, 5'd1, 5'd0, 3'd1, 32'd0,         32'h0000_0013, 1'b1});

    repeat (2) @(negedge clk);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_word", b8.out_word, 0);
    chk("rst_out_addr", b8.out_addr, 0);
    chk("rst_count", count8, 0);
    chk("rst_err", err8, 0);
    chk("rst_done", done8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_in_ready", b8.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", b8.in_ready, 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Randomized stream against the model.
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    exp_addr = 0; exp_cnt = 0; exp_err = 0;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic mready;
      chk("rnd_valid", b8.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_word", b8.out_word, q[0]);
        chk("rnd_addr", b8.out_addr, exp_addr);
      end
      chk("rnd_err", err8, exp_err);
      chk("rnd_count", count8, exp_cnt);
      b8.in_class  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      b8.in_alu    = 4'($urandom_range(0, 11));
      b8.in_rd     = 5'($urandom);
      b8.in_rs1    = 5'($urandom);
      b8.in_rs2    = 5'($urandom);
      b8.in_funct3 = 3'($urandom);
      b8.in_imm    = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h1F);
      b8.in_last   = 1'b0;
      b8.in_valid  = $urandom_range(0, 2) != 0;
      b8.out_ready = $urandom_range(0, 3) != 0;
      #1;
      mready = (q.size() == 0) || b8.out_ready;
      chk("rnd_in_ready", b8.in_ready, mready);
      if (q.size() != 0 && b8.out_ready) begin
        void'(q.pop_front());
        exp_addr = (exp_addr + 1) % 256;
        if (exp_cnt < 256) exp_cnt++;
      end
      if (b8.in_valid && mready) begin
        r = ref_enc(b8.in_class, b8.in_alu, b8.in_rd, b8.in_rs1, b8.in_rs2, b8.in_funct3, b8.in_imm);
        q.push_back(r[31:0]);
        if (r[32]) exp_err = 1;
      end
      @(negedge clk);
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b0;

    // Restart from RUN discards pending word, then back-pressure for 3 cycles.
    start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    chk("restart_valid", b8.out_valid, 0);
    chk("restart_count", count8, 0);
    chk("restart_err", err8, 0);
    drive8(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
    @(negedge clk);
    drive8(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_valid", b8.out_valid, 1);
      chk("stall_word", b8.out_word, 32'h0050_0093);
      chk("stall_addr", b8.out_addr, 0);
      chk("stall_in_ready", b8.in_ready, 0);
      @(negedge clk);
    end
    b8.out_ready = 1'b1;
    #1 chk("release_in_ready", b8.in_ready, 1);
    @(negedge clk); b8.in_valid = 1'b0;
    chk("nobubble_valid", b8.out_valid, 1);
    chk("nobubble_word", b8.out_word, 32'h0020_81B3);
    chk("nobubble_addr", b8.out_addr, 1);
    chk("nobubble_count", count8, 1);
    @(negedge clk);
    chk("stall_done", done8, 1);
    chk("stall_count", count8, 2);
    b8.out_ready = 1'b0;

    // Illegal word pending, then reset together with start and a handshake.
    start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    drive8(4'd0, 4'd2, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", b8.out_valid, 1);
    chk("pre_reset_err", err8, 1);
    chk("pre_reset_word", b8.out_word, 32'h13);
    reset = 1'b1; start8 = 1'b1; b8.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", b8.out_valid, 0);
    chk("midrst_word", b8.out_word, 0);
    chk("midrst_addr", b8.out_addr, 0);
    chk("midrst_count", count8, 0);
    chk("midrst_err", err8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_in_ready", b8.in_ready, 0);
    reset = 1'b0; start8 = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy8, 0);

    // ADDR_W=2: address wraps, count saturates at 4.
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    b2.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        r = ref_enc(4'd1, 4'd0, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i - 1));
        chk($sformatf("w2_addr%0d", i - 1), b2.out_addr, (i - 1) % 4);
        chk($sformatf("w2_word%0d", i - 1), b2.out_word, r[31:0]);
        chk($sformatf("w2_valid%0d", i - 1), b2.out_valid, 1);
      end
      if (i == 5) chk("w2_count_at4", count2, 4);
      if (i < 5) begin
        b2.in_class = 4'd1; b2.in_alu = 4'd0; b2.in_rd = 5'(i + 1); b2.in_rs1 = 5'd0;
        b2.in_rs2 = 5'd0; b2.in_funct3 = 3'd0; b2.in_imm = 32'(i);
        b2.in_last = (i == 4); b2.in_valid = 1'b1;
      end else begin
        b2.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("w2_done", done2, 1);
    chk("w2_busy", busy2, 0);
    chk("w2_count_sat", count2, 4);
    chk("w2_err", err2, 0);
    b2.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
